dcache_param: RTL
=================

# dcache_param

Parametrised write-back, write-allocate data cache that sits between the CPU datapath (byte-wide loads and stores) and the block-wide data memory. It generalises the team's direct-mapped cache controller in four ways: configurable address width, block size, set count and associativity (1- or 2-way with LRU replacement); a fully synchronous FSM with a defined memory handshake; and hit/miss performance counters.

## Interface
- ADDR_W, 8, CPU byte-address width.
- BLOCK_BYTES, 4, bytes per block; power of two, at least 2; offset width OFF_W = log2(BLOCK_BYTES).
- SETS, 8, number of sets; power of two; index width IDX_W = log2(SETS).
- WAYS, 2, associativity; legal values are 1 and 2.
- CNT_W, 16, width of each performance counter.
- Tag width TAG_W = ADDR_W − IDX_W − OFF_W; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- read  in  1  CPU load request.
- write  in  1  CPU store request.
- ADDRESSCPU  in  ADDR_W  CPU byte address.
- WRITEDATACPU  in  8  store data.
- READDATACPU  out  8  load data.
- busywait  out  1  stall to CPU.
- mem_read  out  1  block read request to memory.
- mem_write  out  1  block write request to memory.
- mem_address  out  ADDR_W−OFF_W  block address to memory.
- mem_writedata  out  8·BLOCK_BYTES  write-back block.
- mem_readdata  in  8·BLOCK_BYTES  refill block.
- mem_busywait  in  1  memory stall.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

## Operation
- Address split: tag = [ADDR_W−1 : IDX_W+OFF_W], index = [IDX_W+OFF_W−1 : OFF_W], offset = [OFF_W−1 : 0].
- Each line holds valid, dirty, tag and a data block. With WAYS=2, each set also holds one LRU bit that names the least recently used way.
- Hit: the request is active, and some way in the indexed set is valid with a matching tag.
- Victim on a miss: the first invalid way (way 0 preferred). If both ways are valid, the LRU way is the victim. With WAYS=1, way 0 is always the victim.
- If read and write are both high, the access is treated as a read and WRITEDATACPU is ignored.
- FSM states:
  - IDLE, on a hit: no stall. For a hit write, the byte is written and the line's dirty bit is set at the next posedge. The LRU bit is updated to point at the other way.
  - IDLE, on a miss: go to WRITE_BACK if the victim is valid and dirty; otherwise go to MEM_READ. The miss is counted on this transition.
  - WRITE_BACK: drive mem_write=1, mem_address={victim tag, index} and mem_writedata=victim block. Leave on completion and go to MEM_READ.
  - MEM_READ: drive mem_read=1 and mem_address={tag, index}. On completion, capture mem_readdata and go to UPDATE.
  - UPDATE: install the captured block into the victim way with valid=1, dirty=0 and the new tag. Set LRU to point at the other way. Go to IDLE, where the access now hits.
- Memory completion: the first posedge in the state where mem_busywait=0. mem_busywait is ignored in the first cycle of each state. Request, address and write data stay stable until completion.
- hit_count increments on the posedge where an access completes as a hit and was not the retry of a miss.
- Both counters saturate at their all-ones value.
- Outside WRITE_BACK and MEM_READ, mem_read=0 and mem_write=0, and mem_address and mem_writedata are held at 0.

## Timing
- busywait = (read|write) & !(state==IDLE & hit). It is combinational and goes high in the same cycle a miss request appears.
- READDATACPU is combinational: the selected byte of the hitting way while a read hits, otherwise 0.
- Hit read and hit write each take 0 stall cycles; the access completes at the first posedge.
- Clean miss latency: 1 cycle (IDLE→MEM_READ) + M cycles of memory time + 1 (UPDATE) + 1 hit cycle. busywait falls in the hit cycle.
- Dirty miss adds the full WRITE_BACK duration ahead of MEM_READ.
- Reset values: state IDLE; all valid, dirty and LRU bits 0; busywait 0 when no request; mem_read, mem_write, mem_address and mem_writedata all 0; READDATACPU 0; both counters 0.
- Reset asserted mid-transaction aborts it immediately and drops the memory request the same cycle. Dirty data is lost by design.
- The CPU must hold read, write, ADDRESSCPU and WRITEDATACPU stable while busywait=1. Changes during a stall are undefined.

## Test plan
Memory model: mem_busywait stays high for 4 cycles after a request, then low for one cycle. Defaults are ADDR_W=8, BLOCK_BYTES=4, SETS=8, WAYS=2.
- Reset, then read 0x05 (clean miss) → MEM_READ with mem_address=0x01. Refill block 0xDDCCBBAA. busywait then falls with READDATACPU=0xBB. Counts: miss_count=1, hit_count=0.
- Write 0x5A to 0x06 right after the previous refill → 0 stall cycles. Line becomes dirty. A following read of 0x06 returns 0x5A and hit_count increments.
- Read 0x25, then 0x45 (same index 1, tags 1 and 2) → 0x25 fills way 1. 0x45 evicts the dirty tag-0 line (LRU): WRITE_BACK with mem_address=0x01 and mem_writedata=0xDD5ABBAA, then MEM_READ with mem_address=0x11.
- Re-read 0x25 after the previous scenario → hit with no memory traffic. A re-read of 0x05 misses and evicts the clean LRU way with no WRITE_BACK.
- Assert reset during MEM_READ → mem_read drops to 0 in the same cycle, and all outputs and counters go to 0. A read of the same address afterwards misses again.
- Force 2^CNT_W + 3 hits with CNT_W=4 → hit_count holds at 0xF. Build with WAYS=1: 0x05 then 0x25 must evict each other on every access.

Source files
------------

// File: rtl/dcache_param.sv
// dcache_param: parametrised write-back, write-allocate data cache (1- or 2-way, LRU) with hit/miss counters.
// Ports: clk/reset (async, active-high); CPU side read, write, ADDRESSCPU, WRITEDATACPU -> READDATACPU, busywait;
// memory side mem_read, mem_write, mem_address (block address), mem_writedata <- mem_readdata, mem_busywait;
// hit_count, miss_count saturating performance counters.
module dcache_param #(
    parameter int ADDR_W      = 8,
    parameter int BLOCK_BYTES = 4,
    parameter int SETS        = 8,
    parameter int WAYS        = 2,
    parameter int CNT_W       = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  read,
    input  logic                                  write,
    input  logic [ADDR_W-1:0]                     ADDRESSCPU,
    input  logic [7:0]                            WRITEDATACPU,
    output logic [7:0]                            READDATACPU,
    output logic                                  busywait,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0] mem_address,
    output logic [8*BLOCK_BYTES-1:0]              mem_writedata,
    input  logic [8*BLOCK_BYTES-1:0]              mem_readdata,
    input  logic                                  mem_busywait,
    output logic [CNT_W-1:0]                      hit_count,
    output logic [CNT_W-1:0]                      miss_count
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BW    = 8 * BLOCK_BYTES;

    typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;
    state_t state_q, state_d;

    // Storage is always sized for two ways; with WAYS=1 way 1 is never selected and is pruned.
    logic [1:0]       valid_q [SETS];
    logic [1:0]       dirty_q [SETS];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q  [2][SETS];
    logic [BW-1:0]    data_q [2][SETS];
    logic [BW-1:0]    fill_q;
    logic             vic_q, vic_d, first_q, retry_q;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic [1:0]       hv;
    logic             req, is_wr, hit, hw, vic, idle_hit, done;

    assign tag      = ADDRESSCPU[ADDR_W-1 -: TAG_W];
    assign idx      = ADDRESSCPU[OFF_W +: IDX_W];
    assign off      = ADDRESSCPU[OFF_W-1:0];
    assign req      = read | write;
    assign is_wr    = write & ~read;
    assign hv[0]    = valid_q[idx][0] && tag_q[0][idx] == tag;
    assign hv[1]    = (WAYS == 2) && valid_q[idx][1] && tag_q[1][idx] == tag;
    assign hit      = req & |hv;
    assign hw       = ~hv[0];
    assign vic      = (WAYS == 1 || !valid_q[idx][0]) ? 1'b0 : !valid_q[idx][1] ? 1'b1 : lru_q[idx];
    assign idle_hit = state_q == IDLE && hit;
    // mem_busywait is not trusted in the first cycle of a memory state
    assign done     = !first_q && !mem_busywait;

    assign busywait      = req & ~idle_hit;
    assign READDATACPU   = (read && idle_hit) ? data_q[hw][idx][{off, 3'b000} +: 8] : 8'h00;
    assign mem_write     = state_q == WRITE_BACK;
    assign mem_read      = state_q == MEM_READ;
    assign mem_address   = mem_write ? {tag_q[vic_q][idx], idx} : mem_read ? {tag, idx} : '0;
    assign mem_writedata = mem_write ? data_q[vic_q][idx] : '0;

    always_comb begin
        state_d = state_q;
        vic_d   = vic_q;
        case (state_q)
            IDLE: if (req && !hit) begin
                vic_d   = vic;
                state_d = (valid_q[idx][vic] && dirty_q[idx][vic]) ? WRITE_BACK : MEM_READ;
            end
            WRITE_BACK: state_d = done ? MEM_READ : WRITE_BACK;
            MEM_READ:   state_d = done ? UPDATE : MEM_READ;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            vic_q      <= 1'b0;
            first_q    <= 1'b0;
            retry_q    <= 1'b0;
            valid_q    <= '{default: '0};
            dirty_q    <= '{default: '0};
            lru_q      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q <= state_d;
            vic_q   <= vic_d;
            first_q <= state_d != state_q;
            // the hit that follows UPDATE is the retry of an already counted miss
            retry_q <= state_q == UPDATE;
            if (idle_hit && !retry_q && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (state_q == IDLE && req && !hit && miss_count != '1)
                miss_count <= miss_count + 1'b1;
            if (idle_hit) begin
                lru_q[idx] <= ~hw;
                if (is_wr)
                    dirty_q[idx][hw] <= 1'b1;
            end
            if (state_q == UPDATE) begin
                valid_q[idx][vic_q] <= 1'b1;
                dirty_q[idx][vic_q] <= 1'b0;
                lru_q[idx]          <= ~vic_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (idle_hit && is_wr)
            data_q[hw][idx][{off, 3'b000} +: 8] <= WRITEDATACPU;
        if (state_q == MEM_READ && done)
            fill_q <= mem_readdata;
        if (state_q == UPDATE) begin
            data_q[vic_q][idx] <= fill_q;
            tag_q[vic_q][idx]  <= tag;
        end
    end
endmodule
